// File: rtl/msdf_pkg.sv
// rtl/msdf_pkg.sv - shared MSDF digit definitions, FSM states and digit encoder
package msdf_pkg;

  localparam int DIGIT_W = 2;
  localparam int ENC_SD  = 0;
  localparam int ENC_BS  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // msb_flag marks the negatively weighted leading digit of a two's-complement fraction.
  function automatic logic [DIGIT_W-1:0] encode_digit(input logic msb_flag,
                                                      input logic bit_v,
                                                      input logic mode);
    logic [DIGIT_W-1:0] d;
    if (mode) begin
      d = msb_flag ? {1'b0, bit_v} : {bit_v, 1'b0};
    end else begin
      d = msb_flag ? {bit_v, bit_v} : {1'b0, bit_v};
    end
    return d;
  endfunction

endpackage

// File: rtl/msdf_digit_shifter.sv
// rtl/msdf_digit_shifter.sv - loadable MSB-first operand shift register with digit counter
module msdf_digit_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int PREC_W     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_msb,
  output logic [PREC_W-1:0]     o_count
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [PREC_W-1:0]     cnt_q, cnt_d;

  // A load on the final beat of a frame wins over the shift of that beat.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (i_load) begin
      sr_d  = i_data;
      cnt_d = '0;
    end else if (i_shift) begin
      sr_d  = {sr_q[DATA_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + PREC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_msb   = sr_q[DATA_WIDTH-1];
  assign o_count = cnt_q;

endmodule

// File: rtl/msdf_operand_serializer.sv
// rtl/msdf_operand_serializer.sv - serializes operand pairs into MSDF digit pairs on the mbus write channel
module msdf_operand_serializer
  import msdf_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ENCODING_MODE = 0,
  parameter int PREC_W        = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [DATA_WIDTH-1:0] i_op_x,
  input  logic [DATA_WIDTH-1:0] i_op_y,
  input  logic [PREC_W-1:0]     i_op_prec,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  output logic                  o_mbus_wen,
  output logic [DIGIT_W-1:0]    o_mbus_wdata_x,
  output logic [DIGIT_W-1:0]    o_mbus_wdata_y,
  output logic                  o_mbus_wvalid,
  output logic                  o_mbus_wlast,
  input  logic                  i_mbus_wready,
  output logic                  o_busy
);

  localparam logic [PREC_W-1:0] FULL_PREC = PREC_W'(DATA_WIDTH);
  localparam logic              MODE      = (ENCODING_MODE == ENC_BS);

  state_e            state_q, state_d;
  logic [PREC_W-1:0] prec_q, prec_d;
  logic [PREC_W-1:0] eff_prec;
  logic [PREC_W-1:0] count_x, count_y;
  logic              msb_x, msb_y;
  logic              is_send, last_beat, op_ready, accept, shift;

  assign eff_prec = ((i_op_prec == '0) || (i_op_prec > FULL_PREC)) ? FULL_PREC : i_op_prec;

  always_comb begin
    state_d   = state_q;
    prec_d    = prec_q;
    is_send   = (state_q == SEND);
    last_beat = is_send && (count_x == (prec_q - PREC_W'(1)));
    op_ready  = !is_send || (last_beat && i_mbus_wready);
    accept    = i_op_valid && op_ready;
    shift     = is_send && i_mbus_wready;
    if (accept) begin
      prec_d = eff_prec;
    end
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last_beat && i_mbus_wready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      prec_q  <= '0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
    end
  end

  msdf_digit_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .PREC_W    (PREC_W)
  ) u_shift_x (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (accept),
    .i_shift(shift),
    .i_data (i_op_x),
    .o_msb  (msb_x),
    .o_count(count_x)
  );

  msdf_digit_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .PREC_W    (PREC_W)
  ) u_shift_y (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (accept),
    .i_shift(shift),
    .i_data (i_op_y),
    .o_msb  (msb_y),
    .o_count(count_y)
  );

  // Both counters advance in lockstep; each picks its own leading-digit flag.
  assign o_mbus_wdata_x = is_send ? encode_digit(count_x == '0, msb_x, MODE) : '0;
  assign o_mbus_wdata_y = is_send ? encode_digit(count_y == '0, msb_y, MODE) : '0;
  assign o_mbus_wen     = is_send;
  assign o_mbus_wvalid  = is_send;
  assign o_mbus_wlast   = last_beat;
  assign o_op_ready     = op_ready;
  assign o_busy         = is_send;

endmodule

// File: tb/tb_msdf_operand_serializer.sv
// tb/tb_msdf_operand_serializer.sv - directed vector bench for msdf_operand_serializer
module tb_msdf_operand_serializer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  op_x, op_y;
  logic [PW-1:0] op_prec;
  logic          op_valid, wready;

  logic       o_op_ready, o_wen, o_wvalid, o_wlast, o_busy;
  logic [1:0] o_wx, o_wy;
  logic       b_op_ready, b_wen, b_wvalid, b_wlast, b_busy;
  logic [1:0] b_wx, b_wy;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic [PW-1:0]   prec;
    int              n;
    logic [0:7][1:0] sx;
    logic [0:7][1:0] sy;
    logic [0:7][1:0] bx;
    logic [0:7][1:0] by;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  msdf_operand_serializer #(.DATA_WIDTH(W), .ENCODING_MODE(0), .PREC_W(PW)) u_dut (
    .i_clk(clk), .i_rstn(rst_n), .i_op_x(op_x), .i_op_y(op_y), .i_op_prec(op_prec),
    .i_op_valid(op_valid), .o_op_ready(o_op_ready), .o_mbus_wen(o_wen),
    .o_mbus_wdata_x(o_wx), .o_mbus_wdata_y(o_wy), .o_mbus_wvalid(o_wvalid),
    .o_mbus_wlast(o_wlast), .i_mbus_wready(wready), .o_busy(o_busy)
  );

  msdf_operand_serializer #(.DATA_WIDTH(W), .ENCODING_MODE(1), .PREC_W(PW)) u_dut_bs (
    .i_clk(clk), .i_rstn(rst_n), .i_op_x(op_x), .i_op_y(op_y), .i_op_prec(op_prec),
    .i_op_valid(op_valid), .o_op_ready(b_op_ready), .o_mbus_wen(b_wen),
    .o_mbus_wdata_x(b_wx), .o_mbus_wdata_y(b_wy), .o_mbus_wvalid(b_wvalid),
    .o_mbus_wlast(b_wlast), .i_mbus_wready(wready), .o_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic [PW-1:0] p,
                              input int n, input logic [15:0] sx, input logic [15:0] sy,
                              input logic [15:0] bx, input logic [15:0] by);
    vec_t v;
    v.x = x; v.y = y; v.prec = p; v.n = n;
    v.sx = sx; v.sy = sy; v.bx = bx; v.by = by;
    return v;
  endfunction

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " busy_after"}, o_busy, 1'b0);
    chk({tag, " wvalid_after"}, o_wvalid, 1'b0);
    chk({tag, " ready_after"}, o_op_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    while (!o_op_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, " ready_before"}, o_op_ready, 1'b1);
    op_x = v.x; op_y = v.y; op_prec = v.prec; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op_x = 8'h5A; op_y = 8'hA5; op_prec = 4'd7;
    for (int b = 0; b < v.n; b++) begin
      @(negedge clk);
      chk($sformatf("%s wvalid b%0d", tag, b), o_wvalid, 1'b1);
      chk($sformatf("%s wen b%0d", tag, b), o_wen, 1'b1);
      chk($sformatf("%s x b%0d", tag, b), o_wx, v.sx[b]);
      chk($sformatf("%s y b%0d", tag, b), o_wy, v.sy[b]);
      chk($sformatf("%s wlast b%0d", tag, b), o_wlast, (b == v.n - 1));
      chk($sformatf("%s bs_x b%0d", tag, b), b_wx, v.bx[b]);
      chk($sformatf("%s bs_y b%0d", tag, b), b_wy, v.by[b]);
      chk($sformatf("%s bs_wlast b%0d", tag, b), b_wlast, (b == v.n - 1));
      @(posedge clk); #1;
    end
    check_idle(tag);
  endtask

  initial begin
    int b, cyc;
    vecs[0] = mk(8'h60, 8'h80, 4'd0, 8, 16'b00_01_01_00_00_00_00_00, 16'b11_00_00_00_00_00_00_00,
                 16'b00_10_10_00_00_00_00_00, 16'b01_00_00_00_00_00_00_00);
    vecs[1] = mk(8'hFF, 8'hA0, 4'd3, 3, 16'b11_01_01_00_00_00_00_00, 16'b11_00_01_00_00_00_00_00,
                 16'b01_10_10_00_00_00_00_00, 16'b01_00_10_00_00_00_00_00);
    vecs[2] = mk(8'h35, 8'hC3, 4'd9, 8, 16'b00_00_01_01_00_01_00_01, 16'b11_01_00_00_00_00_01_01,
                 16'b00_00_10_10_00_10_00_10, 16'b01_10_00_00_00_00_10_10);
    vecs[3] = mk(8'h80, 8'h7F, 4'd1, 1, 16'b11_00_00_00_00_00_00_00, 16'b00_00_00_00_00_00_00_00,
                 16'b01_00_00_00_00_00_00_00, 16'b00_00_00_00_00_00_00_00);
    vecs[4] = mk(8'h01, 8'hFE, 4'd8, 8, 16'b00_00_00_00_00_00_00_01, 16'b11_01_01_01_01_01_01_00,
                 16'b00_00_00_00_00_00_00_10, 16'b01_10_10_10_10_10_10_00);

    // Reset with a pair offered: it must be ignored.
    rst_n = 1'b0; op_x = 8'hFF; op_y = 8'hFF; op_prec = 4'd2; op_valid = 1'b1; wready = 1'b1;
    #3;
    chk("rst wen", o_wen, 1'b0);
    chk("rst wvalid", o_wvalid, 1'b0);
    chk("rst wlast", o_wlast, 1'b0);
    chk("rst wdata_x", o_wx, 2'b00);
    chk("rst wdata_y", o_wy, 2'b00);
    chk("rst busy", o_busy, 1'b0);
    chk("rst ready", o_op_ready, 1'b1);
    @(posedge clk); @(posedge clk); #2;
    op_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_rst");
    chk("post_rst bs_wen", b_wen, 1'b0);
    chk("post_rst bs_busy", b_busy, 1'b0);
    chk("post_rst bs_ready", b_op_ready, 1'b1);
    chk("post_rst bs_wvalid", b_wvalid, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: wready pattern 1,0,0 repeating; digits must hold during stalls.
    @(posedge clk); #1;
    op_x = 8'h60; op_y = 8'h80; op_prec = 4'd0; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    b = 0; cyc = 0;
    while (b < 8 && cyc < 100) begin
      wready = (cyc % 3 == 0);
      @(negedge clk);
      chk($sformatf("stall wvalid c%0d", cyc), o_wvalid, 1'b1);
      chk($sformatf("stall x c%0d", cyc), o_wx, vecs[0].sx[b]);
      chk($sformatf("stall y c%0d", cyc), o_wy, vecs[0].sy[b]);
      chk($sformatf("stall wlast c%0d", cyc), o_wlast, (b == 7));
      if (wready) b++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall beats", b, 8);
    chk("stall cycles", cyc, 22);
    wready = 1'b1;
    check_idle("stall");

    // Back-to-back frames with P=2.
    @(posedge clk); #1;
    op_x = 8'h40; op_y = 8'hC0; op_prec = 4'd2; op_valid = 1'b1;
    @(posedge clk); #1;
    op_x = 8'hA0; op_y = 8'h60;
    @(negedge clk);
    chk("b2b b1 x", o_wx, 2'b00); chk("b2b b1 y", o_wy, 2'b11);
    chk("b2b b1 wlast", o_wlast, 1'b0); chk("b2b b1 ready", o_op_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b b2 x", o_wx, 2'b01); chk("b2b b2 y", o_wy, 2'b01);
    chk("b2b b2 wlast", o_wlast, 1'b1); chk("b2b b2 ready", o_op_ready, 1'b1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("b2b b3 wvalid", o_wvalid, 1'b1);
    chk("b2b b3 x", o_wx, 2'b11); chk("b2b b3 y", o_wy, 2'b00);
    chk("b2b b3 wlast", o_wlast, 1'b0); chk("b2b b3 ready", o_op_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b b4 x", o_wx, 2'b00); chk("b2b b4 y", o_wy, 2'b01);
    chk("b2b b4 wlast", o_wlast, 1'b1); chk("b2b b4 ready", o_op_ready, 1'b1);
    @(posedge clk); #1;
    check_idle("b2b");

    // Reset in the middle of a frame.
    @(posedge clk); #1;
    op_x = 8'h60; op_y = 8'h80; op_prec = 4'd0; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid x b%0d", i), o_wx, vecs[0].sx[i]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid b3 wvalid", o_wvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst wen", o_wen, 1'b0);
    chk("mid rst wvalid", o_wvalid, 1'b0);
    chk("mid rst wlast", o_wlast, 1'b0);
    chk("mid rst wdata_x", o_wx, 2'b00);
    chk("mid rst wdata_y", o_wy, 2'b00);
    chk("mid rst busy", o_busy, 1'b0);
    chk("mid rst ready", o_op_ready, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid post ready", o_op_ready, 1'b1);
    chk("mid post wvalid", o_wvalid, 1'b0);
    @(posedge clk); #1;
    run_vec(vecs[1], "mid_next");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
